// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, wd,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo, wd,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO; 32 steps plus one fix-up cycle.
//   state | meaning
//   IDLE  | accepts start or MTHI/MTLO writes
//   RUN   | one shift-add or restoring-divide step per cycle, 32 cycles
//   FIX   | sign correction, HI/LO update, done pulse next cycle
module muldiv_unit (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] divisor;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [63:0] step_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign signed_op = ~bus.op[0];
  assign a_mag = (signed_op && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign b_mag = (signed_op && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // In multiply mode divisor holds the multiplicand and acc[31:0] the multiplier.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
  assign shifted = {acc[63:32], acc[31]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    step_next = {mul_sum, acc[31:1]};
    if (is_div) begin
      if (diff[32]) step_next = {shifted[31:0], acc[30:0], 1'b0};
      else          step_next = {diff[31:0],    acc[30:0], 1'b1};
    end
  end

  // Divide-by-zero leaves the dividend magnitude as remainder, so the sign fix restores a.
  assign prod_fix = neg_q ? (64'd0 - acc) : acc;
  assign quot_fix = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc[31:0]) : acc[31:0]);
  assign rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= 5'd0;
      acc      <= 64'd0;
      divisor  <= 32'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            count  <= 5'd31;
            is_div <= bus.op[1];
            neg_q  <= signed_op & (bus.a[31] ^ bus.b[31]);
            if (bus.op[1]) begin
              acc      <= {32'd0, a_mag};
              divisor  <= b_mag;
              neg_r    <= signed_op & bus.a[31];
              div_zero <= (bus.b == 32'd0);
            end else begin
              acc      <= {32'd0, b_mag};
              divisor  <= a_mag;
              neg_r    <= 1'b0;
              div_zero <= 1'b0;
            end
          end else begin
            if (bus.mthi) hi_q <= bus.wd;
            if (bus.mtlo) lo_q <= bus.wd;
          end
        end
        RUN: begin
          acc   <= step_next;
          count <= count - 5'd1;
          if (count == 5'd0) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
